muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock,
// so every operation takes exactly XLEN iterations regardless of operand values.
// Signed operands are reduced to magnitudes at capture, and the sign is restored
// when the result is registered.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1Data,
   input  logic [XLEN-1:0] rs2Data,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} stateType;

   stateType          state;
   logic [2:0]        op;
   logic [XLEN-1:0]   operand;    // multiplicand magnitude or divisor magnitude
   logic [2*XLEN-1:0] acc;        // {partial product, multiplier} or {remainder, quotient}
   logic [CW-1:0]     count;
   logic              negResult;  // result must be negated on completion
   logic              divZero;

   logic              rs1Signed, rs2Signed, rs1Neg, rs2Neg;
   logic [XLEN-1:0]   rs1Abs, rs2Abs;
   logic [XLEN:0]     addSum, trialDiff;
   logic [2*XLEN-1:0] accNext, prodSigned;
   logic [XLEN-1:0]   quot, remd, finalResult;

   // Operand signedness and magnitudes for the operation being requested.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      rs1Signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
      rs2Signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      rs1Neg    = rs1Signed && rs1Data[XLEN-1];
      rs2Neg    = rs2Signed && rs2Data[XLEN-1];
      rs1Abs    = rs1Neg ? -rs1Data : rs1Data;
      rs2Abs    = rs2Neg ? -rs2Data : rs2Data;
   end

   // One iteration of the datapath: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      addSum    = '0;
      trialDiff = '0;
      accNext   = acc;
      if (op[2]) begin
         // Shift the next dividend bit into the remainder and try the subtraction.
         trialDiff = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
         if (!trialDiff[XLEN]) begin
            accNext = {trialDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end else begin
            accNext = {acc[2*XLEN-2:0], 1'b0};
         end
      end else begin
         // Add the multiplicand when the current multiplier bit is set, then shift right.
         addSum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
         accNext = {addSum, acc[XLEN-1:1]};
      end
   end

   // Sign-corrected result as it will look after the final iteration.
   always_comb begin
      prodSigned  = negResult ? -accNext : accNext;
      quot        = negResult ? -accNext[XLEN-1:0] : accNext[XLEN-1:0];
      remd        = negResult ? -accNext[2*XLEN-1:XLEN] : accNext[2*XLEN-1:XLEN];
      finalResult = remd;
      case (op)
         3'b000:                 finalResult = prodSigned[XLEN-1:0];
         3'b001, 3'b010, 3'b011: finalResult = prodSigned[2*XLEN-1:XLEN];
         3'b100, 3'b101:         finalResult = divZero ? '1 : quot;
         default:                finalResult = remd;
      endcase
   end

   // Control FSM and datapath registers; reset beats flush, flush beats start.
   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the datapath registers are cleared too, not just the control state,
         // so nothing from an aborted operation survives a reset.
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         op        <= '0;
         operand   <= '0;
         acc       <= '0;
         count     <= '0;
         negResult <= 1'b0;
         divZero   <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= CALC;
                  busy      <= 1'b1;
                  op        <= funct3;
                  count     <= '0;
                  negResult <= (funct3 == 3'b110) ? rs1Neg : (rs1Neg ^ rs2Neg);
                  divZero   <= (rs2Data == '0);
                  if (funct3[2]) begin
                     operand <= rs2Abs;
                     acc     <= {{XLEN{1'b0}}, rs1Abs};
                  end else begin
                     operand <= rs1Abs;
                     acc     <= {{XLEN{1'b0}}, rs2Abs};
                  end
               end
            end
            CALC: begin
               acc   <= accNext;
               count <= count + 1'b1;
               if (count == CW'(XLEN - 1)) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= finalResult;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance share one stimulus stream
// (the 8-bit one sees the low operand bytes) and are compared against an
// arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1Data, rs2Data;
   logic        busy32, done32, busy8, done8;
   logic [31:0] result32;
   logic [7:0]  result8;

   int          testsRun = 0;
   int          testsFailed = 0;
   logic [31:0] lastExp32 = '0;
   logic [31:0] lastExp8 = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut32 (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .rs1Data(rs1Data), .rs2Data(rs2Data), .flush(flush),
      .busy(busy32), .done(done32), .result(result32)
   );

   muldiv_unit #(.XLEN(8)) dut8 (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .rs1Data(rs1Data[7:0]), .rs2Data(rs2Data[7:0]), .flush(flush),
      .busy(busy8), .done(done8), .result(result8)
   );

   // Reference result from plain arithmetic on xl-bit operands.
   function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input int xl);
      logic [63:0] mask, ua, ub, sa, sb, prod, res;
      longint      sl1, sl2;
      mask = (64'd1 << xl) - 64'd1;
      ua   = {32'd0, a} & mask;
      ub   = {32'd0, b} & mask;
      sa   = ua[xl-1] ? (ua | ~mask) : ua;
      sb   = ub[xl-1] ? (ub | ~mask) : ub;
      sl1  = sa;
      sl2  = sb;
      res  = '0;
      case (f)
         3'b000: begin prod = ua * ub; res = prod; end
         3'b001: begin prod = sa * sb; res = prod >> xl; end
         3'b010: begin prod = sa * ub; res = prod >> xl; end
         3'b011: begin prod = ua * ub; res = prod >> xl; end
         3'b100: begin
            if (ub == 0) res = mask;
            else if (ua == (64'd1 << (xl - 1)) && ub == mask) res = ua;
            else res = sl1 / sl2;
         end
         3'b101: res = (ub == 0) ? mask : ua / ub;
         3'b110: begin
            if (ub == 0) res = ua;
            else if (ua == (64'd1 << (xl - 1)) && ub == mask) res = 0;
            else res = sl1 % sl2;
         end
         default: res = (ub == 0) ? ua : ua % ub;
      endcase
      res = res & mask;
      return res[31:0];
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'hFFFF_FF80;
         default: return $urandom;
      endcase
   endfunction

   // Runs one operation starting in the current cycle and checks timing and result
   // of both instances. restartAt > 0 re-asserts start with other operands in that cycle.
   task automatic doOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int restartAt, input string name,
                       output logic [31:0] got32, output logic [31:0] got8);
      logic [31:0] exp32, exp8;
      int busyIn32 = 0, busyOut32 = 0, doneCnt32 = 0, doneAt32 = -1;
      int busyIn8 = 0, busyOut8 = 0, doneCnt8 = 0, doneAt8 = -1;
      exp32   = refModel(f, a, b, 32);
      exp8    = refModel(f, a, b, 8);
      funct3  = f;
      rs1Data = a;
      rs2Data = b;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      funct3  = 3'($urandom_range(0, 7));
      rs1Data = $urandom;
      rs2Data = $urandom;
      for (int k = 1; k <= 35; k++) begin
         if (busy32) begin if (k <= 32) busyIn32++; else busyOut32++; end
         if (busy8)  begin if (k <= 8)  busyIn8++;  else busyOut8++;  end
         if (done32) begin doneCnt32++; doneAt32 = k; end
         if (done8)  begin doneCnt8++;  doneAt8 = k;  end
         start = (k == restartAt);
         if (k == restartAt) begin
            funct3  = 3'($urandom_range(0, 7));
            rs1Data = $urandom;
            rs2Data = $urandom;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      got32 = result32;
      got8  = {24'd0, result8};
      lastExp32 = exp32;
      lastExp8  = exp8;
      testsRun++;
      if ((busyIn32 !== 32) || (busyOut32 !== 0)) begin
         testsFailed++;
         $display("FAIL %s busy32: %0d in-window / %0d outside, required 32 / 0", name, busyIn32, busyOut32);
      end
      testsRun++;
      if ((doneCnt32 !== 1) || (doneAt32 !== 33)) begin
         testsFailed++;
         $display("FAIL %s done32: %0d pulses, last in cycle %0d, required 1 in cycle 33", name, doneCnt32, doneAt32);
      end
      testsRun++;
      if (got32 !== exp32) begin
         testsFailed++;
         $display("FAIL %s result32 f=%0d a=%h b=%h: got %h, required %h", name, f, a, b, got32, exp32);
      end
      testsRun++;
      if ((busyIn8 !== 8) || (busyOut8 !== 0)) begin
         testsFailed++;
         $display("FAIL %s busy8: %0d in-window / %0d outside, required 8 / 0", name, busyIn8, busyOut8);
      end
      testsRun++;
      if ((doneCnt8 !== 1) || (doneAt8 !== 9)) begin
         testsFailed++;
         $display("FAIL %s done8: %0d pulses, last in cycle %0d, required 1 in cycle 9", name, doneCnt8, doneAt8);
      end
      testsRun++;
      if (got8 !== exp8) begin
         testsFailed++;
         $display("FAIL %s result8 f=%0d a=%h b=%h: got %h, required %h", name, f, a[7:0], b[7:0], got8, exp8);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; flush = 1'b0;
      funct3 = '0; rs1Data = '0; rs2Data = '0;
      repeat (3) @(posedge clk);
      #1;
      testsRun++;
      if ({busy32, done32, result32, busy8, done8, result8} !== '0) begin
         testsFailed++;
         $display("FAIL reset outputs: busy32=%b done32=%b result32=%h busy8=%b done8=%b result8=%h, required all 0",
                  busy32, done32, result32, busy8, done8, result8);
      end
      reset = 1'b0;
   endtask

   task automatic test_mul();
      logic [31:0] r32, r8;
      doOp(3'b000, 32'd7, 32'hFFFF_FFFD, 0, "mul", r32, r8);
      testsRun++;
      if (r32 !== 32'hFFFF_FFEB) begin
         testsFailed++;
         $display("FAIL mul const: got %h, required ffffffeb", r32);
      end
   endtask

   task automatic test_mulh();
      logic [31:0] r32, r8;
      logic [2:0]  fs [3]  = '{3'b001, 3'b011, 3'b010};
      logic [31:0] as [3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exs [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         doOp(fs[i], as[i], as[i], 0, "mulh", r32, r8);
         testsRun++;
         if (r32 !== exs[i]) begin
            testsFailed++;
            $display("FAIL mulh const f=%0d: got %h, required %h", fs[i], r32, exs[i]);
         end
      end
   endtask

   task automatic test_div();
      logic [31:0] r32, r8;
      logic [2:0]  fs [8]  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
      logic [31:0] as [8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs [8]  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exs [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'hFFFF_FFFF, 32'd5,
                               32'h8000_0000, 32'd0};
      for (int i = 0; i < 8; i++) begin
         doOp(fs[i], as[i], bs[i], 0, "div", r32, r8);
         testsRun++;
         if (r32 !== exs[i]) begin
            testsFailed++;
            $display("FAIL div const f=%0d a=%h b=%h: got %h, required %h", fs[i], as[i], bs[i], r32, exs[i]);
         end
      end
   endtask

   task automatic test_xlen8();
      logic [31:0] r32, r8;
      doOp(3'b011, 32'h0000_00FF, 32'h0000_00FF, 0, "x8 mulhu", r32, r8);
      testsRun++;
      if (r8 !== 32'h0000_00FE) begin
         testsFailed++;
         $display("FAIL x8 mulhu const: got %h, required fe", r8);
      end
      doOp(3'b100, 32'h0000_0080, 32'h0000_00FF, 0, "x8 div", r32, r8);
      testsRun++;
      if (r8 !== 32'h0000_0080) begin
         testsFailed++;
         $display("FAIL x8 div overflow const: got %h, required 80", r8);
      end
   endtask

   task automatic test_restart();
      logic [31:0] r32, r8;
      for (int i = 0; i < 4; i++)
         doOp(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 5, "restart", r32, r8);
   endtask

   task automatic test_flush();
      logic [31:0] prev32;
      int doneCnt32 = 0, doneCnt8 = 0;
      prev32  = lastExp32;
      funct3  = 3'b000;
      rs1Data = 32'd3;
      rs2Data = 32'd5;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         if (done32) doneCnt32++;
         if (done8)  doneCnt8++;
         if (k == 11) begin
            testsRun++;
            if ((busy32 !== 1'b0) || (busy8 !== 1'b0)) begin
               testsFailed++;
               $display("FAIL flush busy cycle 11: busy32=%b busy8=%b, required 0 0", busy32, busy8);
            end
         end
         flush = (k == 10);
         start = (k == 10);
         if (k == 10) begin
            funct3  = 3'b011;
            rs1Data = $urandom;
            rs2Data = $urandom;
         end
         @(posedge clk); #1;
      end
      flush = 1'b0;
      start = 1'b0;
      testsRun++;
      if ((doneCnt32 !== 0) || (result32 !== prev32)) begin
         testsFailed++;
         $display("FAIL flush dut32: %0d done pulses, result %h, required 0 pulses and %h", doneCnt32, result32, prev32);
      end
      lastExp8 = refModel(3'b000, 32'd3, 32'd5, 8);
      testsRun++;
      if ((doneCnt8 !== 1) || ({24'd0, result8} !== lastExp8)) begin
         testsFailed++;
         $display("FAIL flush dut8: %0d done pulses, result %h, required 1 pulse and %h", doneCnt8, result8, lastExp8);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r32, r8;
      funct3  = 3'b100;
      rs1Data = 32'h1234_5678;
      rs2Data = 32'd9;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k < 20; k++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      flush = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      flush = 1'b0;
      start = 1'b0;
      testsRun++;
      if ({busy32, done32, result32, busy8, done8, result8} !== '0) begin
         testsFailed++;
         $display("FAIL reset mid-op cycle 21: busy32=%b done32=%b result32=%h busy8=%b done8=%b result8=%h, required all 0",
                  busy32, done32, result32, busy8, done8, result8);
      end
      doOp(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 0, "after reset", r32, r8);
   endtask

   task automatic test_random();
      logic [31:0] r32, r8;
      for (int i = 0; i < 60; i++)
         doOp(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 0, "random", r32, r8);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_xlen8();
      test_restart();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
